// File: rtl/vmodel_sequencer.sv
// vmodel_sequencer
// ----------------
// Stream-side controller for the fixed-latency vmodel inference datapath.
// Input samples are taken over a valid/ready stream and written into the
// model input register. A tag pipeline, aligned with the model latency,
// marks which model outputs belong to real samples. Those outputs are
// captured into a first-word-fall-through output FIFO. Credit accounting
// (samples in flight + FIFO occupancy) throttles the input. The model has no
// stall, so this guarantees that every result has a FIFO slot waiting for it.
//
// Ports
//   clk           rising-edge clock
//   resetn        synchronous active-low reset
//   s_valid/s_ready/s_data/s_last   input sample stream
//   m_valid/m_ready/m_data/m_last   result stream (FWFT FIFO head)
//   model_inp     registered model input, to vmodel.model_inp
//   model_out     model result, from vmodel.model_out
//   busy          at least one sample in flight or buffered
//   sample_count  results delivered since reset (wraps)

module vmodel_sequencer #(
    parameter int IN_W       = 60,
    parameter int OUT_W      = 70,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             m_last,
    output logic [IN_W-1:0]  model_inp,
    input  logic [OUT_W-1:0] model_out,
    output logic             busy,
    output logic [CNT_W-1:0] sample_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_V = (PTR_W + 1)'(FIFO_DEPTH);

    // Tag stage 0 is loaded on the same edge as model_inp, so it describes
    // the value currently held in model_inp. That value's result is on
    // model_out LATENCY cycles later, which is when the tag reaches stage
    // LATENCY. Hence the pipeline carries LATENCY+1 tag positions.
    logic [LATENCY:0]  tag_valid_reg;
    logic [LATENCY:0]  tag_last_reg;

    logic [IN_W-1:0]   model_inp_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    fifo_count_reg;
    logic [PTR_W:0]    fifo_count_next;
    logic [PTR_W:0]    outstanding_reg;
    logic [PTR_W:0]    outstanding_next;
    logic [CNT_W-1:0]  sample_count_reg;

    // FIFO storage is not reset: the count and pointers alone decide what
    // is valid. The read is asynchronous so the head is visible immediately.
    logic [OUT_W:0]    fifo_mem [FIFO_DEPTH];
    logic [OUT_W:0]    head_entry;

    logic accept;
    logic pop;
    logic capture;
    logic fifo_nonempty;

    // s_ready depends only on registers and on resetn, so it has no path
    // from m_ready or s_valid.
    assign s_ready       = resetn && (outstanding_reg < DEPTH_V);
    assign fifo_nonempty = (fifo_count_reg != '0);
    assign m_valid       = resetn && fifo_nonempty;
    assign head_entry    = fifo_mem[rd_ptr_reg];
    assign m_data        = head_entry[OUT_W-1:0];
    assign m_last        = m_valid && head_entry[OUT_W];
    assign busy          = resetn && (outstanding_reg != '0);
    assign model_inp     = model_inp_reg;
    assign sample_count  = sample_count_reg;

    assign accept  = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    assign capture = tag_valid_reg[LATENCY];

    always_comb begin
        fifo_count_next = fifo_count_reg;
        case ({capture, pop})
            2'b10:   fifo_count_next = fifo_count_reg + 1'b1;
            2'b01:   fifo_count_next = fifo_count_reg - 1'b1;
            default: fifo_count_next = fifo_count_reg;
        endcase
    end

    // A sample owns a credit from its accept until its result is popped;
    // the move from tag pipeline to FIFO does not change the total.
    always_comb begin
        outstanding_next = outstanding_reg;
        case ({accept, pop})
            2'b10:   outstanding_next = outstanding_reg + 1'b1;
            2'b01:   outstanding_next = outstanding_reg - 1'b1;
            default: outstanding_next = outstanding_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tag_valid_reg    <= '0;
            tag_last_reg     <= '0;
            model_inp_reg    <= '0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            fifo_count_reg   <= '0;
            outstanding_reg  <= '0;
            sample_count_reg <= '0;
        end else begin
            tag_valid_reg   <= {tag_valid_reg[LATENCY-1:0], accept};
            tag_last_reg    <= {tag_last_reg[LATENCY-1:0], accept && s_last};
            if (accept) begin
                model_inp_reg <= s_data;
            end
            if (capture) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg       <= rd_ptr_reg + 1'b1;
                sample_count_reg <= sample_count_reg + 1'b1;
            end
            fifo_count_reg  <= fifo_count_next;
            outstanding_reg <= outstanding_next;
        end
    end

    // Writes are gated by resetn so results emerging during reset are dropped.
    always_ff @(posedge clk) begin
        if (resetn && capture) begin
            fifo_mem[wr_ptr_reg] <= {tag_last_reg[LATENCY], model_out};
        end
    end

endmodule

// File: tb/tb_vmodel_sequencer.sv
// Testbench for vmodel_sequencer. A stub model delays model_inp by LATENCY
// cycles. The reference is a queue of accepted samples, each stamped with
// the edge from which its result becomes visible. Every cycle the bench
// compares s_ready, m_valid, m_data, m_last, busy, sample_count and model_inp
// with the values the queue predicts.

module tb_vmodel_sequencer;

    localparam int IN_W       = 60;
    localparam int OUT_W      = 70;
    localparam int LATENCY    = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 32;

    logic             clk;
    logic             resetn;
    logic             s_valid;
    logic             s_ready;
    logic [IN_W-1:0]  s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [OUT_W-1:0] m_data;
    logic             m_last;
    logic [IN_W-1:0]  model_inp;
    logic [OUT_W-1:0] model_out;
    logic             busy;
    logic [CNT_W-1:0] sample_count;

    vmodel_sequencer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .LATENCY(LATENCY),
        .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .resetn(resetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .model_inp(model_inp), .model_out(model_out),
        .busy(busy), .sample_count(sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub model: output is the input zero-extended, LATENCY registers later.
    logic [IN_W-1:0] stub_pipe [LATENCY];
    always @(posedge clk) begin
        stub_pipe[0] <= model_inp;
        for (int i = 1; i < LATENCY; i++) stub_pipe[i] <= stub_pipe[i-1];
    end
    assign model_out = {10'h0, stub_pipe[LATENCY-1]};

    typedef struct {
        logic [IN_W-1:0] data;
        logic            last;
        int              avail;   // first edge after which the result is visible
    } item_t;

    item_t           q[$];
    int              edge_n = 0;
    int              checks = 0;
    int              failures = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic [IN_W-1:0]  exp_inp = '0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, edge_n);
        end
    endtask

    function automatic logic [IN_W-1:0] rnd60();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[IN_W-1:0];
    endfunction

    // One clock cycle: drive inputs, check outputs against the queue model,
    // then follow the actual handshakes across the edge.
    task automatic tick(input logic rn, input logic sv, input logic [IN_W-1:0] sd,
                        input logic sl, input logic mr);
        logic  exp_valid;
        logic  acc;
        logic  pp;
        item_t it;
        @(negedge clk);
        resetn  = rn;
        s_valid = sv;
        s_data  = sd;
        s_last  = sl;
        m_ready = mr;
        #1;
        exp_valid = rn && (q.size() > 0) && (q[0].avail <= edge_n);
        chk("s_ready", 72'(s_ready), 72'(rn && (q.size() < FIFO_DEPTH)));
        chk("m_valid", 72'(m_valid), 72'(exp_valid));
        chk("busy", 72'(busy), 72'(rn && (q.size() != 0)));
        chk("sample_count", 72'(sample_count), 72'(exp_cnt));
        chk("model_inp", 72'(model_inp), 72'(exp_inp));
        if (exp_valid) begin
            chk("m_data", 72'(m_data), 72'({10'h0, q[0].data}));
            chk("m_last", 72'(m_last), 72'(q[0].last));
        end else if (!rn) begin
            chk("m_last_rst", 72'(m_last), 72'(0));
        end
        acc = rn && sv && s_ready;
        pp  = rn && m_valid && mr;
        @(posedge clk);
        edge_n++;
        if (!rn) begin
            q.delete();
            exp_cnt = '0;
            exp_inp = '0;
        end else begin
            if (pp) begin
                checks++;
                assert (q.size() > 0) else begin
                    failures++;
                    $error("FAIL pop_empty observed=pop expected=no_result at edge %0d", edge_n);
                end
                if (q.size() > 0) void'(q.pop_front());
                exp_cnt++;
            end
            if (acc) begin
                it.data  = sd;
                it.last  = sl;
                it.avail = edge_n + LATENCY + 1;
                q.push_back(it);
                exp_inp = sd;
            end
            // More than FIFO_DEPTH unanswered samples means a FIFO write while full.
            checks++;
            assert (q.size() <= FIFO_DEPTH) else begin
                failures++;
                $error("FAIL fifo_overflow observed=%0d expected<=%0d", q.size(), FIFO_DEPTH);
            end
        end
    endtask

    initial begin
        logic [4:0] last_pat;
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        @(posedge clk);

        // Reset state
        repeat (2) tick(0, 0, '0, 0, 0);

        // Single sample
        tick(1, 1, 60'h123, 1, 1);
        repeat (10) tick(1, 0, '0, 0, 1);

        // Streaming 1..20
        for (int i = 1; i <= 20; i++) tick(1, 1, IN_W'(i), 0, 1);
        repeat (10) tick(1, 0, '0, 0, 1);

        // Backpressure, single pop pulse, then full with accept+pop each cycle
        for (int i = 0; i < 14; i++) tick(1, 1, rnd60(), 0, 0);
        tick(1, 1, rnd60(), 0, 1);
        for (int i = 0; i < 4; i++) tick(1, 1, rnd60(), 0, 0);
        for (int i = 0; i < 20; i++) tick(1, 1, rnd60(), 1'($urandom_range(0, 1)), 1);
        repeat (12) tick(1, 0, '0, 0, 1);

        // Frame marker pattern 0,0,1,0,1
        last_pat = 5'b10100;
        for (int i = 0; i < 5; i++) tick(1, 1, rnd60(), last_pat[i], 1);
        repeat (10) tick(1, 0, '0, 0, 1);

        // Random traffic
        for (int i = 0; i < 300; i++)
            tick(1, 1'($urandom_range(0, 1)), rnd60(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 150; i++)
            tick(1, 1'($urandom_range(0, 3) != 0), rnd60(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0));
        repeat (20) tick(1, 0, '0, 0, 1);

        // Reset mid-flight: stale stub outputs must be dropped
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick(1, 1, rnd60(), 0, 1);
        tick(0, 0, '0, 0, 1);
        repeat (10) tick(1, 0, '0, 0, 1);
        tick(1, 1, 60'hA, 0, 1);
        repeat (10) tick(1, 0, '0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
